// File: rtl/div_signed_pkg.sv
// Shared types and constants for the sequential signed divider.
// The divide-by-zero result fills (quotient -1, remainder 0) are kept here.
package div_signed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic DBZ_QUOT_FILL = 1'b1;
    localparam logic DBZ_REM_FILL  = 1'b0;

endpackage

// File: rtl/div_signed_step.sv
// One restoring division iteration: shift in the next dividend bit,
// trial-subtract |divisor|, keep the difference or restore.
module div_signed_step #(
    parameter int width = 10
) (
    input  logic [width:0]   prem,
    input  logic             bit_in,
    input  logic [width-1:0] dsr,
    output logic [width:0]   prem_next,
    output logic             q_bit
);

    logic [width:0]   shifted;
    logic [width+1:0] diff;

    always_comb begin
        shifted   = {prem[width-1:0], bit_in};
        // prem stays below dsr, so its MSB is zero; folding it in keeps the subtraction exact
        diff      = {prem[width], shifted} - {2'b00, dsr};
        q_bit     = ~diff[width+1];
        prem_next = q_bit ? diff[width:0] : shifted;
    end

endmodule

// File: rtl/div_signed_seq.sv
// Sequential signed divider, one restoring bit per clock, truncating like '/' and '%'.
// Define DIV_SIGNED_DBZ_EN to add the registered dbz (divide-by-zero) output.
module div_signed_seq
    import div_signed_pkg::*;
#(
    parameter int width = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*width-1:0]   dividend,
    input  logic [width-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*width-1:0]   quotient,
    output logic [width-1:0]     remainder,
`ifdef DIV_SIGNED_DBZ_EN
    output logic                 dbz,
`endif
    output div_state_t           dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, and out_valid plus results hold until out_ready.

    localparam int DW = 2 * width;
    localparam int CW = $clog2(DW + 1);

    div_state_t       state;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    dvd_mag;
    logic [DW-2:0]    quo_mag;
    logic [DW-1:0]    quo_next;
    logic [width-1:0] dsr_mag;
    logic [width:0]   prem;
    logic [width:0]   prem_next;
    logic             q_bit;
    logic             q_neg;
    logic             r_neg;
    logic [DW-1:0]    dividend_mag;
    logic [width-1:0] divisor_mag;

    assign in_ready  = (state == IDLE);
    assign dbg_state = state;

    // |-2^(DW-1)| wraps to the same bit pattern, which is the correct unsigned magnitude
    always_comb begin
        dividend_mag = dividend[DW-1] ? -dividend : dividend;
        divisor_mag  = divisor[width-1] ? -divisor : divisor;
        quo_next     = {quo_mag, q_bit};
    end

    div_signed_step #(.width(width)) u_step (
        .prem      (prem),
        .bit_in    (dvd_mag[DW-1]),
        .dsr       (dsr_mag),
        .prem_next (prem_next),
        .q_bit     (q_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            cnt       <= '0;
            dvd_mag   <= '0;
            quo_mag   <= '0;
            dsr_mag   <= '0;
            prem      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`ifdef DIV_SIGNED_DBZ_EN
            dbz       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        q_neg   <= dividend[DW-1] ^ divisor[width-1];
                        r_neg   <= dividend[DW-1];
                        dvd_mag <= dividend_mag;
                        dsr_mag <= divisor_mag;
                        prem    <= '0;
                        quo_mag <= '0;
                        cnt     <= CW'(DW);
                        if (divisor == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            quotient  <= {DW{DBZ_QUOT_FILL}};
                            remainder <= {width{DBZ_REM_FILL}};
`ifdef DIV_SIGNED_DBZ_EN
                            dbz       <= 1'b1;
`endif
                        end else begin
                            state <= CALC;
`ifdef DIV_SIGNED_DBZ_EN
                            dbz   <= 1'b0;
`endif
                        end
                    end
                end
                CALC: begin
                    prem    <= prem_next;
                    dvd_mag <= {dvd_mag[DW-2:0], 1'b0};
                    quo_mag <= quo_next[DW-2:0];
                    cnt     <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= q_neg ? -quo_next : quo_next;
                        remainder <= r_neg ? -prem_next[width-1:0] : prem_next[width-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
`ifdef DIV_SIGNED_DBZ_EN
                        dbz       <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
